// File: rtl/parking_occupancy_ctrl.sv
// Multi-lane parking occupancy controller: per-lane beam-sequence FSMs feeding a shared
// saturating occupancy counter. Optional input debounce is enabled by PARK_DEBOUNCE_EN.
module parking_occupancy_ctrl #(
    parameter int N_LANES    = 2,
    parameter int CAPACITY   = 100,
    parameter int CNT_W      = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LANES-1:0] sens_a,
    input  logic [N_LANES-1:0] sens_b,
    input  logic               clear,
    output logic [N_LANES-1:0] entry_pulse,
    output logic [N_LANES-1:0] exit_pulse,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               overflow_err,
    output logic               underflow_err
);

    typedef enum logic [2:0] {
        IDLE, EN1, EN2, EN3, EX1, EX2, EX3
    } lane_state_t;

    localparam int SW = CNT_W + 4;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

    logic [N_LANES-1:0] w_sa;
    logic [N_LANES-1:0] w_sb;

`ifdef PARK_DEBOUNCE_EN
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [2*N_LANES-1:0] r_sync1;
    logic [2*N_LANES-1:0] r_sync2;
    logic [2*N_LANES-1:0] r_filt;
    logic [DW-1:0]        r_deb_cnt [2*N_LANES];

    // A filtered bit only flips after DEB_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_filt  <= '0;
            for (int k = 0; k < 2*N_LANES; k++) r_deb_cnt[k] <= '0;
        end else begin
            r_sync1 <= {sens_a, sens_b};
            r_sync2 <= r_sync1;
            for (int k = 0; k < 2*N_LANES; k++) begin
                if (r_sync2[k] == r_filt[k]) begin
                    r_deb_cnt[k] <= '0;
                end else if (r_deb_cnt[k] == DEB_LAST) begin
                    r_filt[k]    <= r_sync2[k];
                    r_deb_cnt[k] <= '0;
                end else begin
                    r_deb_cnt[k] <= r_deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign {w_sa, w_sb} = r_filt;
`else
    assign w_sa = sens_a;
    assign w_sb = sens_b;
`endif

    lane_state_t        r_state [N_LANES];
    lane_state_t        w_next  [N_LANES];
    logic [N_LANES-1:0] w_entry_evt;
    logic [N_LANES-1:0] w_exit_evt;
    logic [N_LANES-1:0] r_entry_pulse;
    logic [N_LANES-1:0] r_exit_pulse;

    // Exit states mirror the entry states with the roles of A and B swapped.
    always_comb begin
        w_entry_evt = '0;
        w_exit_evt  = '0;
        for (int i = 0; i < N_LANES; i++) begin
            w_next[i] = r_state[i];
            case (r_state[i])
                IDLE: case ({w_sa[i], w_sb[i]})
                    2'b10:   w_next[i] = EN1;
                    2'b01:   w_next[i] = EX1;
                    default: w_next[i] = IDLE;
                endcase
                EN1: case ({w_sa[i], w_sb[i]})
                    2'b11:   w_next[i] = EN2;
                    2'b10:   w_next[i] = EN1;
                    default: w_next[i] = IDLE;
                endcase
                EN2: case ({w_sa[i], w_sb[i]})
                    2'b01:   w_next[i] = EN3;
                    2'b10:   w_next[i] = EN1;
                    2'b11:   w_next[i] = EN2;
                    default: w_next[i] = IDLE;
                endcase
                EN3: case ({w_sa[i], w_sb[i]})
                    2'b00: begin
                        w_next[i]      = IDLE;
                        w_entry_evt[i] = 1'b1;
                    end
                    2'b11:   w_next[i] = EN2;
                    2'b01:   w_next[i] = EN3;
                    default: w_next[i] = IDLE;
                endcase
                EX1: case ({w_sa[i], w_sb[i]})
                    2'b11:   w_next[i] = EX2;
                    2'b01:   w_next[i] = EX1;
                    default: w_next[i] = IDLE;
                endcase
                EX2: case ({w_sa[i], w_sb[i]})
                    2'b10:   w_next[i] = EX3;
                    2'b01:   w_next[i] = EX1;
                    2'b11:   w_next[i] = EX2;
                    default: w_next[i] = IDLE;
                endcase
                EX3: case ({w_sa[i], w_sb[i]})
                    2'b00: begin
                        w_next[i]     = IDLE;
                        w_exit_evt[i] = 1'b1;
                    end
                    2'b11:   w_next[i] = EX2;
                    2'b10:   w_next[i] = EX3;
                    default: w_next[i] = IDLE;
                endcase
                default: w_next[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_LANES; i++) r_state[i] <= IDLE;
            r_entry_pulse <= '0;
            r_exit_pulse  <= '0;
        end else begin
            for (int i = 0; i < N_LANES; i++) r_state[i] <= w_next[i];
            r_entry_pulse <= w_entry_evt;
            r_exit_pulse  <= w_exit_evt;
        end
    end

    logic signed [SW-1:0] w_n_ent;
    logic signed [SW-1:0] w_n_ext;
    logic signed [SW-1:0] w_cnt_next;
    logic [CNT_W-1:0]     r_count;
    logic                 r_ovf;
    logic                 r_unf;

    // Entries and exits net out before the clamp, so a balanced cycle at a limit is harmless.
    always_comb begin
        w_n_ent = '0;
        w_n_ext = '0;
        for (int i = 0; i < N_LANES; i++) begin
            w_n_ent = w_n_ent + SW'(w_entry_evt[i]);
            w_n_ext = w_n_ext + SW'(w_exit_evt[i]);
        end
        w_cnt_next = $signed({4'b0000, r_count}) + w_n_ent - w_n_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (w_cnt_next > CAP_S) begin
            r_count <= CNT_W'(CAPACITY);
            r_ovf   <= 1'b1;
        end else if (w_cnt_next < 0) begin
            r_count <= '0;
            r_unf   <= 1'b1;
        end else begin
            r_count <= w_cnt_next[CNT_W-1:0];
        end
    end

    assign entry_pulse   = r_entry_pulse;
    assign exit_pulse    = r_exit_pulse;
    assign count         = r_count;
    assign full          = (r_count == CNT_W'(CAPACITY));
    assign empty         = (r_count == '0);
    assign overflow_err  = r_ovf;
    assign underflow_err = r_unf;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Directed self-checking bench for parking_occupancy_ctrl (two lanes, capacity 8).
module tb_parking_occupancy_ctrl;

   localparam int N_LANES  = 2;
   localparam int CAPACITY = 8;
   localparam int CNT_W    = 8;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [N_LANES-1:0] sens_a = '0;
   logic [N_LANES-1:0] sens_b = '0;
   logic               clear = 1'b0;
   logic [N_LANES-1:0] entry_pulse;
   logic [N_LANES-1:0] exit_pulse;
   logic [CNT_W-1:0]   count;
   logic               full;
   logic               empty;
   logic               overflow_err;
   logic               underflow_err;

   int checks = 0;
   int errors = 0;

   parking_occupancy_ctrl #(
      .N_LANES   (N_LANES),
      .CAPACITY  (CAPACITY),
      .CNT_W     (CNT_W),
      .DEB_CYCLES(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sens_a       (sens_a),
      .sens_b       (sens_b),
      .clear        (clear),
      .entry_pulse  (entry_pulse),
      .exit_pulse   (exit_pulse),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .overflow_err (overflow_err),
      .underflow_err(underflow_err)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // Drive one sensor vector, let one rising edge pass, then settle 1 ns past it
   task automatic applyStimulus(input logic [N_LANES-1:0] a, input logic [N_LANES-1:0] b);
      sens_a = a;
      sens_b = b;
      @(posedge clk);
      #1;
   endtask

   // One immediate-assertion comparison
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Full entry crossing on one lane, one clock per step
   task automatic entrySeq(input int lane);
      logic [N_LANES-1:0] m;
      m = N_LANES'(1 << lane);
      applyStimulus(m, '0);
      applyStimulus(m, m);
      applyStimulus('0, m);
      applyStimulus('0, '0);
   endtask

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_count", int'(count), 0);
      checkOutput("reset_empty", int'(empty), 1);
      checkOutput("reset_full", int'(full), 0);
      checkOutput("reset_pulses", int'({entry_pulse, exit_pulse}), 0);
      checkOutput("reset_errs", int'({overflow_err, underflow_err}), 0);
      rst = 1'b0;
      applyStimulus('0, '0);

      for (int k = 0; k < 5; k++) entrySeq(0);
      checkOutput("preload_count5", int'(count), 5);

      // Lane 0 entry from 5
      applyStimulus(2'b01, 2'b00);
      applyStimulus(2'b01, 2'b01);
      applyStimulus(2'b00, 2'b01);
      checkOutput("entry_no_early_pulse", int'(entry_pulse), 0);
      checkOutput("entry_count_before", int'(count), 5);
      applyStimulus(2'b00, 2'b00);
      checkOutput("entry_pulse_l0", int'(entry_pulse), 1);
      checkOutput("entry_count6", int'(count), 6);
      applyStimulus(2'b00, 2'b00);
      checkOutput("entry_pulse_one_clk", int'(entry_pulse), 0);

      // Lane 1 exit from 6
      applyStimulus(2'b00, 2'b10);
      applyStimulus(2'b10, 2'b10);
      applyStimulus(2'b10, 2'b00);
      applyStimulus(2'b00, 2'b00);
      checkOutput("exit_pulse_l1", int'(exit_pulse), 2);
      checkOutput("exit_count5", int'(count), 5);
      applyStimulus(2'b00, 2'b00);
      checkOutput("exit_pulse_one_clk", int'(exit_pulse), 0);

      // Backing out: 10 -> 11 -> 10 -> 00 on lane 0
      applyStimulus(2'b01, 2'b00);
      applyStimulus(2'b01, 2'b01);
      applyStimulus(2'b01, 2'b00);
      applyStimulus(2'b00, 2'b00);
      applyStimulus(2'b00, 2'b00);
      checkOutput("backout_no_pulse", int'({entry_pulse, exit_pulse}), 0);
      checkOutput("backout_count", int'(count), 5);

      // Fill to capacity
      for (int k = 0; k < 3; k++) entrySeq(1);
      checkOutput("cap_count", int'(count), CAPACITY);
      checkOutput("cap_full", int'(full), 1);
      checkOutput("cap_no_ovf", int'(overflow_err), 0);

      // Lane 0 entry and lane 1 exit completing together at capacity
      applyStimulus(2'b01, 2'b10);
      applyStimulus(2'b11, 2'b11);
      applyStimulus(2'b10, 2'b01);
      applyStimulus(2'b00, 2'b00);
      checkOutput("simul_entry_pulse", int'(entry_pulse), 1);
      checkOutput("simul_exit_pulse", int'(exit_pulse), 2);
      checkOutput("simul_count", int'(count), CAPACITY);
      checkOutput("simul_no_errs", int'({overflow_err, underflow_err}), 0);

      // Entry at capacity is dropped and flagged
      entrySeq(0);
      checkOutput("ovf_pulse", int'(entry_pulse), 1);
      checkOutput("ovf_count", int'(count), CAPACITY);
      checkOutput("ovf_flag", int'(overflow_err), 1);
      applyStimulus('0, '0);
      checkOutput("ovf_sticky", int'(overflow_err), 1);

      clear = 1'b1;
      applyStimulus('0, '0);
      clear = 1'b0;
      checkOutput("clear_count", int'(count), 0);
      checkOutput("clear_empty", int'(empty), 1);
      checkOutput("clear_ovf", int'(overflow_err), 0);

      // Exit at zero is dropped and flagged
      applyStimulus(2'b00, 2'b01);
      applyStimulus(2'b01, 2'b01);
      applyStimulus(2'b01, 2'b00);
      applyStimulus(2'b00, 2'b00);
      checkOutput("unf_pulse", int'(exit_pulse), 1);
      checkOutput("unf_count", int'(count), 0);
      checkOutput("unf_flag", int'(underflow_err), 1);

      // Clear wins over a completing entry, but the pulse is still emitted
      applyStimulus(2'b01, 2'b00);
      applyStimulus(2'b01, 2'b01);
      applyStimulus(2'b00, 2'b01);
      clear = 1'b1;
      applyStimulus(2'b00, 2'b00);
      clear = 1'b0;
      checkOutput("clrprio_pulse", int'(entry_pulse), 1);
      checkOutput("clrprio_count", int'(count), 0);
      checkOutput("clrprio_unf", int'(underflow_err), 0);

      // Two entries resolve in one clock
      applyStimulus(2'b11, 2'b00);
      applyStimulus(2'b11, 2'b11);
      applyStimulus(2'b00, 2'b11);
      applyStimulus(2'b00, 2'b00);
      checkOutput("dual_entry_pulse", int'(entry_pulse), 3);
      checkOutput("dual_entry_count", int'(count), 2);

      // Reset while lane 0 sits in EN2 abandons the crossing
      applyStimulus(2'b01, 2'b00);
      applyStimulus(2'b01, 2'b01);
      rst = 1'b1;
      #2;
      checkOutput("rst_async_count", int'(count), 0);
      rst = 1'b0;
      applyStimulus(2'b00, 2'b01);
      checkOutput("rst_no_pulse_a", int'(entry_pulse), 0);
      applyStimulus(2'b00, 2'b00);
      checkOutput("rst_no_pulse_b", int'(entry_pulse), 0);
      checkOutput("rst_count", int'(count), 0);
      checkOutput("rst_empty", int'(empty), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
